// File: rtl/tt_um_uwasic_onboarding_gianna_binder.sv
// SPI-configured 16-output driver: a write-only mode-0 SPI slave loads five
// control registers that select off / static-high / shared-PWM per output.
module tt_um_uwasic_onboarding_gianna_binder #(
  parameter int CLK_DIV  = 13,
  parameter int MAX_ADDR = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int         DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [6:0] MAX_A = 7'(MAX_ADDR);

  // rst_n keeps its pin-map name but is active-high.
  logic rst;
  assign rst = rst_n;

  logic unused;
  assign unused = &{1'b0, ena, uio_in, ui_in[7:3]};

  logic [1:0] sclk_sync, copi_sync, ncs_sync;
  logic       sclk_prev, ncs_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= 2'b00;
      copi_sync <= 2'b00;
      ncs_sync  <= 2'b00;
      sclk_prev <= 1'b0;
      ncs_prev  <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], ui_in[0]};
      copi_sync <= {copi_sync[0], ui_in[1]};
      ncs_sync  <= {ncs_sync[0], ui_in[2]};
      sclk_prev <= sclk_sync[1];
      ncs_prev  <= ncs_sync[1];
    end
  end

  logic sclk_rise, ncs_fall, ncs_rise;
  assign sclk_rise = sclk_sync[1] & ~sclk_prev;
  assign ncs_fall  = ~ncs_sync[1] & ncs_prev;
  assign ncs_rise  = ncs_sync[1] & ~ncs_prev;

  // The count saturates at 16; a separate overrun flag marks long frames
  // so they can be rejected even though the count reads 16.
  logic [15:0] shift;
  logic [4:0]  bit_cnt;
  logic        overrun;

  always_ff @(posedge clk) begin
    if (rst || ncs_fall) begin
      shift   <= 16'h0000;
      bit_cnt <= 5'd0;
      overrun <= 1'b0;
    end else if (!ncs_sync[1] && sclk_rise) begin
      shift <= {shift[14:0], copi_sync[1]};
      if (bit_cnt == 5'd16) overrun <= 1'b1;
      else                  bit_cnt <= bit_cnt + 5'd1;
    end
  end

  logic [6:0] addr;
  logic       commit;
  assign addr   = shift[14:8];
  assign commit = ncs_rise && (bit_cnt == 5'd16) && !overrun && shift[15] && (addr <= MAX_A);

  logic [15:0] en_out, en_pwm;
  logic [7:0]  duty;

  always_ff @(posedge clk) begin
    if (rst) begin
      en_out <= 16'h0000;
      en_pwm <= 16'h0000;
      duty   <= 8'h00;
    end else if (commit) begin
      case (addr)
        7'd0:    en_out[7:0]  <= shift[7:0];
        7'd1:    en_out[15:8] <= shift[7:0];
        7'd2:    en_pwm[7:0]  <= shift[7:0];
        7'd3:    en_pwm[15:8] <= shift[7:0];
        7'd4:    duty         <= shift[7:0];
        default: ;
      endcase
    end
  end

  logic [DIV_W-1:0] div_cnt;
  logic [7:0]       pwm_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      pwm_cnt <= 8'h00;
    end else if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
      div_cnt <= '0;
      pwm_cnt <= pwm_cnt + 8'd1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  logic pwm;
  assign pwm = (duty == 8'hFF) ? 1'b1 : (pwm_cnt < duty);

  // Registered outputs keep register updates and PWM toggles glitch-free.
  logic [15:0] out_q;
  always_ff @(posedge clk) begin
    if (rst) out_q <= 16'h0000;
    else     out_q <= en_out & (~en_pwm | {16{pwm}});
  end

  assign uo_out  = out_q[7:0];
  assign uio_out = out_q[15:8];
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_uwasic_onboarding_gianna_binder.sv
// Bench for the SPI-configured output driver: vector table, random SPI
// traffic against a register-level model, and PWM timing measurements.
`timescale 1ns/1ps
module tb_tt_um_uwasic_onboarding_gianna_binder;

  localparam int CLK_DIV = 13;
  localparam int PERIOD  = 256 * CLK_DIV;

  logic       clk, rst_n, ena;
  logic       sclk, copi, ncs;
  logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;

  assign ui_in = {5'b00000, ncs, copi, sclk};

  tt_um_uwasic_onboarding_gianna_binder dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Register-level model: five bytes, written only by well-formed writes.
  logic [7:0] m_reg [5];

  task automatic model_reset();
    for (int i = 0; i < 5; i++) m_reg[i] = 8'h00;
  endtask

  task automatic model_frame(input logic [15:0] word, input int nbits);
    int a;
    a = int'(word[14:8]);
    if (nbits == 16 && word[15] && a <= 4) m_reg[a] = word[7:0];
  endtask

  task automatic check_model(input string name);
    logic [15:0] eo, ep, exp, mask, act;
    logic [7:0]  d;
    eo = {m_reg[1], m_reg[0]};
    ep = {m_reg[3], m_reg[2]};
    d  = m_reg[4];
    act = {uio_out, uo_out};
    if (d == 8'h00) begin
      exp = eo & ~ep; mask = 16'hFFFF;
    end else if (d == 8'hFF) begin
      exp = eo; mask = 16'hFFFF;
    end else begin
      exp = eo & ~ep; mask = ~(eo & ep);
    end
    check(name, 32'(act & mask), 32'(exp & mask));
  endtask

  // SPI driver tasks (mode 0, MSB first, SCLK = clk/8).
  task automatic spi_start();
    @(negedge clk);
    ncs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [15:0] word, input int first, input int count);
    int pos;
    for (int k = 0; k < count; k++) begin
      pos  = first + k;
      copi = (pos < 16) ? word[15 - pos] : 1'b0;
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_end();
    repeat (4) @(negedge clk);
    ncs = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic spi_frame(input logic [15:0] word, input int nbits);
    spi_start();
    spi_bits(word, 0, nbits);
    spi_end();
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b0;
    model_reset();
  endtask

  // Measures high time and period of uo_out[0]; ok=0 if any wait times out.
  task automatic measure(output int hi, output int per, output bit ok, output bit others_bad);
    int n;
    ok = 1'b1; hi = 0; per = 0; others_bad = 1'b0;
    n = 0;
    while (uo_out[0] !== 1'b0 && n < 2 * PERIOD) begin @(negedge clk); n++; end
    if (n >= 2 * PERIOD) ok = 1'b0;
    n = 0;
    while (ok && uo_out[0] !== 1'b1 && n < 2 * PERIOD) begin @(negedge clk); n++; end
    if (n >= 2 * PERIOD) ok = 1'b0;
    while (ok && uo_out[0] === 1'b1 && hi < 2 * PERIOD) begin
      if (uo_out[7:1] !== 7'd0 || uio_out !== 8'd0) others_bad = 1'b1;
      @(negedge clk); hi++;
    end
    per = hi;
    while (ok && uo_out[0] === 1'b0 && per < 2 * PERIOD) begin
      if (uo_out[7:1] !== 7'd0 || uio_out !== 8'd0) others_bad = 1'b1;
      @(negedge clk); per++;
    end
    if (hi >= 2 * PERIOD || per >= 2 * PERIOD) ok = 1'b0;
  endtask

  typedef struct {
    logic [15:0] word;
    int          nbits;
    logic [7:0]  exp_uo;
    logic [7:0]  exp_uio;
  } vec_t;

  vec_t vecs [14];

  initial begin
    #(1_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, hi, per, d, nb, sel, a;
    bit ok, ob;
    logic [15:0] w;
    logic [7:0]  dat;

    vecs[0]  = '{16'h80F0, 16, 8'hF0, 8'h00};
    vecs[1]  = '{16'h81CC, 16, 8'hF0, 8'hCC};
    vecs[2]  = '{16'h00FF, 16, 8'hF0, 8'hCC};  // read: no effect
    vecs[3]  = '{16'hB0FF, 16, 8'hF0, 8'hCC};  // address 0x30
    vecs[4]  = '{16'h800F, 12, 8'hF0, 8'hCC};  // short frame
    vecs[5]  = '{16'h403F, 17, 8'hF0, 8'hCC};  // long frame
    vecs[6]  = '{16'h8500, 16, 8'hF0, 8'hCC};  // address 5
    vecs[7]  = '{16'h8133, 16, 8'hF0, 8'h33};
    vecs[8]  = '{16'h8003, 16, 8'h03, 8'h33};
    vecs[9]  = '{16'h8400, 16, 8'h03, 8'h33};
    vecs[10] = '{16'h8201, 16, 8'h02, 8'h33};
    vecs[11] = '{16'h84FF, 16, 8'h03, 8'h33};
    vecs[12] = '{16'h8303, 16, 8'h03, 8'h33};
    vecs[13] = '{16'h8400, 16, 8'h02, 8'h30};

    ena = 1'b1; uio_in = 8'h00;
    sclk = 1'b0; copi = 1'b0; ncs = 1'b1; rst_n = 1'b0;

    // Reset state and idle hold.
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_uo", 32'(uo_out), 32'h00);
    check("reset_uio", 32'(uio_out), 32'h00);
    check("reset_oe", 32'(uio_oe), 32'hFF);
    rst_n = 1'b0;
    model_reset();
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'hFF) bad++;
    end
    check("idle_hold_bad_cycles", 32'(bad), 32'd0);

    // Table-driven frames; each check lands 4 clocks after nCS rises.
    for (int i = 0; i < 14; i++) begin
      spi_frame(vecs[i].word, vecs[i].nbits);
      check($sformatf("vec%0d_uo", i), 32'(uo_out), 32'(vecs[i].exp_uo));
      check($sformatf("vec%0d_uio", i), 32'(uio_out), 32'(vecs[i].exp_uio));
    end

    // nCS rising while SCLK is still high, then a back-to-back frame.
    spi_start();
    spi_bits(16'h80AA, 0, 15);
    copi = 1'b0;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    repeat (4) @(negedge clk);
    ncs = 1'b1;
    repeat (4) @(negedge clk);
    sclk = 1'b0;
    check("ncs_rise_sclk_high", 32'(uo_out), 32'hAA);
    spi_frame(16'h8155, 16);
    check("back_to_back_uio", 32'(uio_out), 32'h54);
    check("back_to_back_uo", 32'(uo_out), 32'hAA);

    // Mid-frame reset aborts the write.
    do_reset(5);
    spi_start();
    spi_bits(16'h80FF, 0, 8);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    spi_bits(16'h80FF, 8, 8);
    spi_end();
    check("mid_frame_reset_uo", 32'(uo_out), 32'h00);
    spi_frame(16'h80FF, 16);
    check("after_reset_write", 32'(uo_out), 32'hFF);

    // Random SPI traffic against the register model.
    do_reset(3);
    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 9);
      nb  = (sel == 0) ? 12 : (sel == 1) ? 17 : (sel == 2) ? 8 : 16;
      a   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 5);
      dat = 8'($urandom_range(0, 255));
      if (a == 4) begin
        sel = $urandom_range(0, 2);
        if (sel == 0) dat = 8'h00;
        else if (sel == 1) dat = 8'hFF;
      end
      w = {($urandom_range(0, 4) != 0), 7'(a), dat};
      spi_frame(w, nb);
      model_frame(w, nb);
      check_model($sformatf("rand%0d_w%h_n%0d", i, w, nb));
    end

    // PWM 50 %.
    do_reset(3);
    spi_frame(16'h8001, 16);
    spi_frame(16'h8201, 16);
    spi_frame(16'h8480, 16);
    measure(hi, per, ok, ob);
    check("pwm50_timeout", 32'(ok), 32'd1);
    check("pwm50_high", 32'(hi), 32'(128 * CLK_DIV));
    check("pwm50_period", 32'(per), 32'(PERIOD));
    check("pwm50_other_bits", 32'(ob), 32'd0);

    // Random duty: high time is duty*CLK_DIV.
    for (int i = 0; i < 2; i++) begin
      d = $urandom_range(1, 254);
      spi_frame({8'h84, 8'(d)}, 16);
      measure(hi, per, ok, ob);
      check($sformatf("pwm_d%0d_timeout", d), 32'(ok), 32'd1);
      check($sformatf("pwm_d%0d_high", d), 32'(hi), 32'(d * CLK_DIV));
      check($sformatf("pwm_d%0d_period", d), 32'(per), 32'(PERIOD));
    end

    // Duty extremes over two periods.
    spi_frame(16'h8400, 16);
    bad = 0;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      @(negedge clk);
      if (uo_out !== 8'h00) bad++;
    end
    check("duty00_bad_cycles", 32'(bad), 32'd0);
    spi_frame(16'h84FF, 16);
    bad = 0;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      @(negedge clk);
      if (uo_out !== 8'h01) bad++;
    end
    check("dutyFF_bad_cycles", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
